// File: rtl/disp_scan_ctrl.sv
// Refresh scanner and frame-synchronous update sequencer for a 4-digit address/data 7-segment display.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading-zero address digits.
module disp_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic [7:0] ad_in,
    input  logic [7:0] d_in,
    output logic       pending,
    output logic [1:0] seg_sel,
    output logic [3:0] anode,
    output logic [3:0] ad_hi,
    output logic [3:0] ad_lo,
    output logic [3:0] d_hi,
    output logic [3:0] d_lo,
    output logic       frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_seg_sel;
    logic [3:0]    r_anode;
    logic          r_frame_tick;
    logic          r_pending;
    logic [7:0]    r_pend_ad;
    logic [7:0]    r_pend_d;
    logic [7:0]    r_ad;
    logic [7:0]    r_d;

    logic          w_wrap;
    logic          w_frame;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_sel_nxt;
    state_t        w_state_nxt;
    logic [7:0]    w_ad_nxt;
    logic [7:0]    w_d_nxt;
    logic [3:0]    w_digit_en;

    always_comb begin
        w_wrap    = (r_cnt == CNT_LAST);
        w_frame   = w_wrap && (r_seg_sel == 2'd3);
        w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
        w_sel_nxt = w_wrap ? r_seg_sel + 2'd1 : r_seg_sel;

        w_state_nxt = r_state;
        case (r_state)
            BLANK: if (w_cnt_nxt == CNT_DEAD) w_state_nxt = SHOW;
            SHOW:  if (w_wrap)                w_state_nxt = BLANK;
            default: w_state_nxt = BLANK;
        endcase

        // A same-cycle update at the frame edge wins over the older pending value
        w_ad_nxt = r_ad;
        w_d_nxt  = r_d;
        if (w_frame) begin
            if (update) begin
                w_ad_nxt = ad_in;
                w_d_nxt  = d_in;
            end else if (r_pending) begin
                w_ad_nxt = r_pend_ad;
                w_d_nxt  = r_pend_d;
            end
        end

        w_digit_en = '1;
`ifdef LEAD_ZERO_BLANK_EN
        if (w_ad_nxt[7:4] == 4'h0) w_digit_en[3] = 1'b0;
        if (w_ad_nxt == 8'h00)     w_digit_en[2] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= BLANK;
            r_cnt        <= '0;
            r_seg_sel    <= '0;
            r_anode      <= '1;
            r_frame_tick <= 1'b0;
            r_pending    <= 1'b0;
            r_pend_ad    <= '0;
            r_pend_d     <= '0;
            r_ad         <= '0;
            r_d          <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_seg_sel    <= w_sel_nxt;
            r_frame_tick <= w_frame;
            r_ad         <= w_ad_nxt;
            r_d          <= w_d_nxt;

            // Anode is decoded from next-state values so it always matches seg_sel
            case (w_state_nxt)
                SHOW:    r_anode <= ~(w_digit_en & (4'b0001 << w_sel_nxt));
                default: r_anode <= '1;
            endcase

            if (w_frame) begin
                r_pending <= 1'b0;
            end else if (update) begin
                r_pend_ad <= ad_in;
                r_pend_d  <= d_in;
                r_pending <= 1'b1;
            end
        end
    end

    assign pending    = r_pending;
    assign seg_sel    = r_seg_sel;
    assign anode      = r_anode;
    assign ad_hi      = r_ad[7:4];
    assign ad_lo      = r_ad[3:0];
    assign d_hi       = r_d[7:4];
    assign d_lo       = r_d[3:0];
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a time-based reference model predicts every cycle's outputs.
module tb_disp_scan_ctrl;

    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = 4 * RD;

    logic       clk = 1'b0;
    logic       reset;
    logic       update;
    logic [7:0] ad_in;
    logic [7:0] d_in;
    logic       pending;
    logic [1:0] seg_sel;
    logic [3:0] anode;
    logic [3:0] ad_hi, ad_lo, d_hi, d_lo;
    logic       frame_tick;

    disp_scan_ctrl #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .update(update), .ad_in(ad_in), .d_in(d_in),
        .pending(pending), .seg_sel(seg_sel), .anode(anode),
        .ad_hi(ad_hi), .ad_lo(ad_lo), .d_hi(d_hi), .d_lo(d_lo),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] an;
        logic [7:0] ad;
        logic [7:0] d;
        logic       pend;
        logic       ft;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int unsigned m_t     = 0;
    logic        m_armed = 1'b0;
    logic [7:0]  m_ad, m_d, m_pad, m_pd;
    logic        m_pend;

    // Reference model: position in the scan follows directly from cycles since reset
    initial begin
        exp_t e;
        int unsigned cnt, sel;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_t = 0; m_ad = '0; m_d = '0; m_pad = '0; m_pd = '0; m_pend = 1'b0;
                m_armed = 1'b1;
            end else if (m_armed) begin
                m_t++;
                if (m_t % FRAME == 0) begin
                    if (update) begin
                        m_ad = ad_in; m_d = d_in;
                    end else if (m_pend) begin
                        m_ad = m_pad; m_d = m_pd;
                    end
                    m_pend = 1'b0;
                end else if (update) begin
                    m_pad = ad_in; m_pd = d_in; m_pend = 1'b1;
                end
            end
            if (m_armed) begin
                cnt    = m_t % RD;
                sel    = (m_t / RD) % 4;
                e.sel  = 2'(sel);
                e.an   = 4'b1111;
                if (cnt >= DC) begin
                    e.an[sel] = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
                    if (sel == 3 && m_ad[7:4] == 4'h0) e.an[sel] = 1'b1;
                    if (sel == 2 && m_ad == 8'h00)     e.an[sel] = 1'b1;
`endif
                end
                e.ad   = m_ad;
                e.d    = m_d;
                e.pend = m_pend;
                e.ft   = (m_t > 0) && (m_t % FRAME == 0);
                q.push_back(e);
            end
        end
    end

    // Monitor: outputs are registered, so every cycle presents a fresh response
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{sel: seg_sel, an: anode, ad: {ad_hi, ad_lo}, d: {d_hi, d_lo},
                      pend: pending, ft: frame_tick};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0d: got sel=%0d an=%b ad=%h d=%h pend=%b ft=%b, expected sel=%0d an=%b ad=%h d=%h pend=%b ft=%b",
                             m_t, a.sel, a.an, a.ad, a.d, a.pend, a.ft,
                             e.sel, e.an, e.ad, e.d, e.pend, e.ft);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_update(input logic [7:0] a, input logic [7:0] d);
        update = 1'b1; ad_in = a; d_in = d;
        tick();
        update = 1'b0;
    endtask

    task automatic wait_phase(input int unsigned ph);
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != ph; k++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; update = 1'b0; ad_in = '0; d_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2 * FRAME + 4) tick();

        wait_phase(10);                       // seg_sel = 1, mid-frame
        do_update(8'hA5, 8'h3C);
        wait_phase(2);

        wait_phase(3);
        do_update(8'h11, 8'h22);
        repeat (3) tick();
        do_update(8'h77, 8'h88);
        wait_phase(2);

        wait_phase(5);
        do_update(8'h11, 8'h11);
        wait_phase(FRAME - 1);                // last cycle before the frame edge
        do_update(8'hF0, 8'h0F);
        repeat (4) tick();

        wait_phase(12);
        do_update(8'h5A, 8'hC3);
        wait_phase(18);                       // seg_sel = 2 with update pending
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (FRAME + 2) tick();

        do_update(8'h05, 8'h99);
        repeat (2 * FRAME) tick();
        do_update(8'h00, 8'h42);
        repeat (2 * FRAME) tick();

        for (int i = 0; i < 40; i++) begin
            int unsigned r;
            repeat ($urandom_range(0, 20)) tick();
            r = $urandom_range(0, 9);
            if (r == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else if (r == 1) begin
                wait_phase(FRAME - 1);
                do_update(8'($urandom), 8'($urandom));
            end else begin
                do_update(8'($urandom), 8'($urandom));
            end
        end
        repeat (FRAME + 2) tick();

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Refresh scanner and update sequencer for the 4-digit address/data 7-segment display. It drives seg_sel into the address/data nibble mux and generates the matching active-low anode enables, with a blanking gap between digits to prevent ghosting. It holds the displayed address and data bytes in shadow registers. Host updates are committed only at a frame boundary, so a frame never shows mixed old and new values.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (100 MHz gives a 2 kHz digit rate); must be >= DEAD_CYCLES+2.
DEAD_CYCLES, 4, all-anodes-off cycles at the start of each digit slot; must be >= 1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
update  input  1  single-cycle request to load ad_in/d_in
ad_in  input  8  new address byte
d_in  input  8  new data byte
pending  output  1  an update is captured but not yet committed
seg_sel  output  2  digit select to the nibble mux (0=d_lo, 1=d_hi, 2=ad_lo, 3=ad_hi)
anode  output  4  active-low digit enables; bit n = digit n
ad_hi  output  4  shadow ad[7:4]
ad_lo  output  4  shadow ad[3:0]
d_hi  output  4  shadow d[7:4]
d_lo  output  4  shadow d[3:0]
frame_tick  output  1  one-cycle pulse when seg_sel wraps 3->0

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous, active-high. All outputs are registered.
- Reset values: seg_sel=0, anode=4'b1111, shadows=0, pending=0, frame_tick=0, slot counter=0, pending regs=0.
- Slot counter: cnt counts 0..REFRESH_DIV-1, then wraps to 0. Width is clog2(REFRESH_DIV).
- At the cnt wrap edge (boundary): seg_sel increments modulo 4 (3->0 wraps).
- frame_tick: asserted for exactly the cycle following the edge where seg_sel becomes 0 from 3.
- Per-slot FSM, two states:
  - BLANK: cnt < DEAD_CYCLES; anode=4'b1111.
  - SHOW: cnt >= DEAD_CYCLES; anode = ~(4'b0001 << seg_sel).
- Anode alignment: anode is computed from next-state cnt/seg_sel, so anode and seg_sel change on the same edge. No cycle ever has an enabled anode paired with a mismatched seg_sel.
- Exit from reset: the first slot is digit 0 and starts in BLANK.
- Update capture: update=1 latches ad_in/d_in into the pending regs and sets pending=1 on the next edge.
- Repeated updates: a further update while pending=1 overwrites the pending regs (last wins). pending stays 1.
- Commit: on the frame-boundary edge (seg_sel 3->0), if pending=1, the pending regs are copied to the shadows and pending clears.
  - The nibble split is ad_hi=ad[7:4], ad_lo=ad[3:0], d_hi=d[7:4], d_lo=d[3:0].
- Update on the boundary cycle: ad_in/d_in are written directly to the shadows, any older pending value is discarded, and pending=0.
- No update pending at the boundary: shadows hold.
- Reset mid-frame: all state returns to reset values on the next edge. Pending data is lost.
- Latency: an update is visible on the shadows at most 4*REFRESH_DIV cycles after capture, and at least 1 cycle after capture.

Optional Feature:
LEAD_ZERO_BLANK_EN: when defined, leading zeros on the address digits are blanked.
- Digit 3 anode stays 1 in SHOW when shadow ad_hi==0.
- Digit 2 anode stays 1 in SHOW when ad_hi==0 and ad_lo==0.
- Data digits 0 and 1 are always shown.
- Blanking is evaluated from the committed shadows only.
- When undefined, all four digits are shown in SHOW.
- seg_sel sequencing and timing are identical in both builds.

Test Plan:
- Reset/scan, REFRESH_DIV=8, DEAD_CYCLES=2: release reset. Expect seg_sel sequence 0,1,2,3,0 with each value held 8 cycles, and anode=1111 for the first 2 cycles of each slot. Then anode=1110, 1101, 1011, 0111 in SHOW. frame_tick pulses once per 32 cycles.
- Deferred commit: update with ad_in=8'hA5, d_in=8'h3C mid-frame at seg_sel=1. Expect pending=1 and shadows unchanged until the 3->0 edge, then ad_hi=A, ad_lo=5, d_hi=3, d_lo=C, and pending=0.
- Last-wins: update 8'h11/8'h22, then 8'h77/8'h88 in the same frame. Expect committed 7,7,8,8.
- Boundary collision: update 8'hF0/8'h0F on the exact boundary cycle while a 8'h11/8'h11 update is pending. Expect shadows F,0,0,F on the next edge and pending=0.
- Reset mid-operation: assert reset with pending=1 at seg_sel=2. Expect seg_sel=0, anode=1111, shadows=0, and pending=0 on the next edge.
- LEAD_ZERO_BLANK_EN defined, commit ad=8'h05: expect the digit 3 anode never low while digit 2 shows. With ad=8'h00, expect digits 2 and 3 never low.
